sram_controller_power_fsm: RTL and testbench



---
 rtl/sram_controller_power_fsm.sv | 188 ++++++++++++++++++
 tb/tb_sram_controller_power_fsm.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller_power_fsm.sv
`default_nettype none
// ============================================================================
// sram_controller_power_fsm : SRAM macro power-state sequencer (auto-sleep, timed wake,
// optional power-gated shutdown enabled by SRAM_CTRL_DEEP_SLEEP_EN).  Rev 1.0
// ============================================================================
module sram_controller_power_fsm #(
  parameter int IDLE_CYCLES  = 16,
  parameter int WAKE_CYCLES  = 4,
  parameter int DEEP_CYCLES  = 256,
  parameter int PWRUP_CYCLES = 8
) (
  input  logic       hclk_i,
  input  logic       hreset_i,
  input  logic       hsel_i,
  input  logic [1:0] htrans_i,
  input  logic       sleep_en_i,
  input  logic       sleep_req_i,
  input  logic       wake_req_i,
  input  logic       ret_lost_clr_i,
  output logic       hready_gate_o,
  output logic [1:0] fsm_state_o,
  output logic       sram_clk_en_o,
  output logic       sram_pwr_en_o,
  output logic       sram_iso_o,
  output logic       ret_lost_o
);

  localparam int IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_ACTIVE = 3'd0,
    ST_SLEEP  = 3'd1,
`ifdef SRAM_CTRL_DEEP_SLEEP_EN
    ST_WAKEUP = 3'd2,
    ST_ISO    = 3'd3,
    ST_OFF    = 3'd4,
    ST_PWRUP  = 3'd5
`else
    ST_WAKEUP = 3'd2
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
  logic              hready_q;
  logic [1:0]        fsm_state_q;
  logic              clk_en_q;
  logic              activity;
  logic              unused_inputs;

  assign activity = hsel_i & htrans_i[1];

`ifdef SRAM_CTRL_DEEP_SLEEP_EN
  localparam int DEEP_W = (DEEP_CYCLES > 1) ? $clog2(DEEP_CYCLES) : 1;
  localparam int PWR_W  = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;
  localparam logic [DEEP_W-1:0] DEEP_LAST = DEEP_W'(DEEP_CYCLES - 1);
  localparam logic [PWR_W-1:0]  PWR_LAST  = PWR_W'(PWRUP_CYCLES - 1);

  logic [DEEP_W-1:0] sleep_cnt_q, sleep_cnt_d;
  logic [PWR_W-1:0]  pwr_cnt_q, pwr_cnt_d;
  logic              pending_q, pending_d;
  logic              ret_lost_q, ret_lost_d;
  logic              pwr_en_q, iso_q;

  assign unused_inputs = htrans_i[0];
`else
  assign unused_inputs = ^{htrans_i[0], ret_lost_clr_i, DEEP_CYCLES[0], PWRUP_CYCLES[0]};
`endif

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = '0;
    wake_cnt_d = '0;
`ifdef SRAM_CTRL_DEEP_SLEEP_EN
    sleep_cnt_d = '0;
    pwr_cnt_d   = '0;
    pending_d   = 1'b0;
    ret_lost_d  = ret_lost_q & ~ret_lost_clr_i;
`endif
    case (state_q)
      ST_ACTIVE: begin
        if (!activity) begin
          idle_cnt_d = (idle_cnt_q == IDLE_LAST) ? idle_cnt_q : idle_cnt_q + IDLE_W'(1);
          if (sleep_req_i || (sleep_en_i && (idle_cnt_q == IDLE_LAST)))
            state_d = ST_SLEEP;
        end
      end
      ST_SLEEP: begin
        if (activity || wake_req_i)
          state_d = ST_WAKEUP;
`ifdef SRAM_CTRL_DEEP_SLEEP_EN
        else if (sleep_en_i && (sleep_cnt_q == DEEP_LAST))
          state_d = ST_ISO;
        else
          sleep_cnt_d = (sleep_cnt_q == DEEP_LAST) ? sleep_cnt_q : sleep_cnt_q + DEEP_W'(1);
`endif
      end
      ST_WAKEUP: begin
        if (wake_cnt_q == WAKE_LAST)
          state_d = ST_ACTIVE;
        else
          wake_cnt_d = wake_cnt_q + WAKE_W'(1);
      end
`ifdef SRAM_CTRL_DEEP_SLEEP_EN
      ST_ISO: begin
        // A wake seen while isolating cannot abort the sequence; remember it for OFF.
        state_d    = ST_OFF;
        pending_d  = activity | wake_req_i;
        ret_lost_d = 1'b1;
      end
      ST_OFF: begin
        if (activity || wake_req_i || pending_q)
          state_d = ST_PWRUP;
        else
          pending_d = pending_q;
      end
      ST_PWRUP: begin
        if (pwr_cnt_q == PWR_LAST)
          state_d = ST_WAKEUP;
        else
          pwr_cnt_d = pwr_cnt_q + PWR_W'(1);
      end
`endif
      default: state_d = ST_ACTIVE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge hclk_i or posedge hreset_i) begin
    if (hreset_i) begin
      state_q     <= ST_ACTIVE;
      idle_cnt_q  <= '0;
      wake_cnt_q  <= '0;
      hready_q    <= 1'b1;
      fsm_state_q <= 2'b00;
      clk_en_q    <= 1'b1;
`ifdef SRAM_CTRL_DEEP_SLEEP_EN
      sleep_cnt_q <= '0;
      pwr_cnt_q   <= '0;
      pending_q   <= 1'b0;
      ret_lost_q  <= 1'b0;
      pwr_en_q    <= 1'b1;
      iso_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      hready_q   <= (state_d == ST_ACTIVE);
      clk_en_q   <= (state_d == ST_ACTIVE) || (state_d == ST_WAKEUP);
      case (state_d)
        ST_SLEEP:  fsm_state_q <= 2'b01;
        ST_WAKEUP: fsm_state_q <= 2'b10;
`ifdef SRAM_CTRL_DEEP_SLEEP_EN
        ST_ISO, ST_OFF, ST_PWRUP: fsm_state_q <= 2'b11;
`endif
        default:   fsm_state_q <= 2'b00;
      endcase
`ifdef SRAM_CTRL_DEEP_SLEEP_EN
      sleep_cnt_q <= sleep_cnt_d;
      pwr_cnt_q   <= pwr_cnt_d;
      pending_q   <= pending_d;
      ret_lost_q  <= ret_lost_d;
      pwr_en_q    <= (state_d != ST_OFF);
      iso_q       <= (state_d == ST_ISO) || (state_d == ST_OFF) || (state_d == ST_PWRUP);
`endif
    end
  end

  assign hready_gate_o = hready_q;
  assign fsm_state_o   = fsm_state_q;
  assign sram_clk_en_o = clk_en_q;
`ifdef SRAM_CTRL_DEEP_SLEEP_EN
  assign sram_pwr_en_o = pwr_en_q;
  assign sram_iso_o    = iso_q;
  assign ret_lost_o    = ret_lost_q;
`else
  assign sram_pwr_en_o = 1'b1;
  assign sram_iso_o    = 1'b0;
  assign ret_lost_o    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_controller_power_fsm.sv
`default_nettype none
// ============================================================================
// tb_sram_controller_power_fsm : directed and random checks against a behavioural power-state model.
// ============================================================================
module tb_sram_controller_power_fsm;

  localparam int IDLE_CYCLES  = 16;
  localparam int WAKE_CYCLES  = 4;
  localparam int DEEP_CYCLES  = 8;
  localparam int PWRUP_CYCLES = 8;
`ifdef SRAM_CTRL_DEEP_SLEEP_EN
  localparam bit DEEP_EN = 1'b1;
`else
  localparam bit DEEP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       hsel, sleep_en, sleep_req, wake_req, ret_lost_clr;
  logic [1:0] htrans;
  logic       hready_gate, sram_clk_en, sram_pwr_en, sram_iso, ret_lost;
  logic [1:0] fsm_state;
  logic [6:0] outs;

  always #5 clk = ~clk;

  sram_controller_power_fsm #(
    .IDLE_CYCLES (IDLE_CYCLES),
    .WAKE_CYCLES (WAKE_CYCLES),
    .DEEP_CYCLES (DEEP_CYCLES),
    .PWRUP_CYCLES(PWRUP_CYCLES)
  ) dut (
    .hclk_i        (clk),
    .hreset_i      (rst),
    .hsel_i        (hsel),
    .htrans_i      (htrans),
    .sleep_en_i    (sleep_en),
    .sleep_req_i   (sleep_req),
    .wake_req_i    (wake_req),
    .ret_lost_clr_i(ret_lost_clr),
    .hready_gate_o (hready_gate),
    .fsm_state_o   (fsm_state),
    .sram_clk_en_o (sram_clk_en),
    .sram_pwr_en_o (sram_pwr_en),
    .sram_iso_o    (sram_iso),
    .ret_lost_o    (ret_lost)
  );

  assign outs = {hready_gate, fsm_state, sram_clk_en, sram_pwr_en, sram_iso, ret_lost};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: modes with unbounded time-in-mode / idle-run counters.
  typedef enum {M_ACTIVE, M_SLEEP, M_WAKEUP, M_ISO, M_OFF, M_PWRUP} mode_e;
  mode_e m_mode;
  int    m_idle_run;
  int    m_age;
  bit    m_pending;
  bit    m_lost;

  function automatic void model_reset();
    m_mode     = M_ACTIVE;
    m_idle_run = 0;
    m_age      = 0;
    m_pending  = 1'b0;
    m_lost     = 1'b0;
  endfunction

  function automatic void model_step(bit act, bit sreq, bit wreq, bit sen, bit clr);
    mode_e nxt;
    nxt = m_mode;
    case (m_mode)
      M_ACTIVE: begin
        if (act) m_idle_run = 0;
        else begin
          if (sreq || (sen && m_idle_run >= IDLE_CYCLES - 1)) nxt = M_SLEEP;
          m_idle_run++;
        end
      end
      M_SLEEP: begin
        if (act || wreq) nxt = M_WAKEUP;
        else if (DEEP_EN && sen && m_age >= DEEP_CYCLES - 1) nxt = M_ISO;
      end
      M_WAKEUP: if (m_age >= WAKE_CYCLES - 1) nxt = M_ACTIVE;
      M_ISO: begin
        nxt = M_OFF;
        m_pending = act || wreq;
      end
      M_OFF: begin
        if (act || wreq || m_pending) begin
          nxt = M_PWRUP;
          m_pending = 1'b0;
        end
      end
      default: if (m_age >= PWRUP_CYCLES - 1) nxt = M_WAKEUP;
    endcase
    if (m_mode == M_ISO) m_lost = 1'b1;
    else if (clr) m_lost = 1'b0;
    if (nxt != m_mode) begin
      m_age = 0;
      if (nxt == M_ACTIVE) m_idle_run = 0;
    end else begin
      m_age++;
    end
    m_mode = nxt;
  endfunction

  function automatic logic [6:0] exp_vec();
    logic [1:0] fs;
    case (m_mode)
      M_ACTIVE: fs = 2'b00;
      M_SLEEP:  fs = 2'b01;
      M_WAKEUP: fs = 2'b10;
      default:  fs = 2'b11;
    endcase
    return {m_mode == M_ACTIVE, fs, (m_mode == M_ACTIVE) || (m_mode == M_WAKEUP),
            m_mode != M_OFF, (m_mode == M_ISO) || (m_mode == M_OFF) || (m_mode == M_PWRUP), m_lost};
  endfunction

  task automatic expect_out(input string tag, input bit hr, input logic [1:0] fs, input bit ce,
                            input bit pe, input bit iso, input bit rl);
    chk(tag, 32'(outs), 32'({hr, fs, ce, pe, iso, rl}));
  endtask

  task automatic step(input bit a, input bit sreq, input bit wreq, input bit sen, input bit clr);
    if (a) begin
      hsel   = 1'b1;
      htrans = {1'b1, 1'($urandom_range(0, 1))};
    end else if ($urandom_range(0, 1) == 1) begin
      hsel   = 1'b1;
      htrans = {1'b0, 1'($urandom_range(0, 1))};
    end else begin
      hsel   = 1'b0;
      htrans = 2'($urandom_range(0, 3));
    end
    sleep_req    = sreq;
    wake_req     = wreq;
    sleep_en     = sen;
    ret_lost_clr = clr;
    @(posedge clk);
    model_step(a, sreq, wreq, sen, clr);
    #1;
    chk("model", 32'(outs), 32'(exp_vec()));
  endtask

  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    expect_out(tag, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1 chk("reset_held", 32'(outs), 32'(exp_vec()));
    #2 rst = 1'b0;
  endtask

  int  pct;
  bit  r_sen;
  bit  r_act;

  initial begin
    rst = 1'b0; hsel = 1'b0; htrans = 2'b00; sleep_en = 1'b0;
    sleep_req = 1'b0; wake_req = 1'b0; ret_lost_clr = 1'b0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    expect_out("reset_vals", 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Auto-sleep on the 16th idle edge.
    repeat (15) step(0, 0, 0, 1, 0);
    expect_out("idle15_active", 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    step(0, 0, 0, 1, 0);
    expect_out("sleep_at_16", 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);

    // Activity wake latency 1 + WAKE_CYCLES.
    step(1, 0, 0, 1, 0);
    expect_out("wake_1edge", 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1, 0, 0, 1, 0);
    expect_out("wake_4edges", 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1, 0, 0, 1, 0);
    expect_out("active_5edges", 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);

    // Activity at idle_cnt==15 wins and clears the count.
    repeat (15) step(0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    expect_out("act_wins_at_15", 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (15) step(0, 0, 0, 1, 0);
    expect_out("idle_cnt_cleared", 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    step(0, 0, 0, 1, 0);
    expect_out("sleep_after_reclear", 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);

    // Forced sleep / wake with sleep_en=0.
    step(0, 0, 1, 1, 0);
    repeat (4) step(0, 0, 0, 0, 0);
    expect_out("back_active", 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    step(0, 1, 0, 0, 0);
    expect_out("sleep_req_sleep", 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    step(0, 1, 0, 0, 0);
    expect_out("sleep_req_ignored", 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    step(0, 0, 1, 0, 0);
    expect_out("wake_req_wakeup", 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) step(0, 1, 0, 0, 0);
    expect_out("wakeup_ignores_req", 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    step(0, 0, 0, 0, 0);
    expect_out("wake_req_active", 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);

    // Saturated idle count sleeps immediately once sleep_en rises.
    repeat (40) step(0, 0, 0, 0, 0);
    expect_out("no_autosleep", 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    step(0, 0, 0, 1, 0);
    expect_out("sat_sleep", 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);

`ifdef SRAM_CTRL_DEEP_SLEEP_EN
    repeat (7) step(0, 0, 0, 1, 0);
    expect_out("sleep_8_still", 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    step(0, 0, 0, 1, 0);
    expect_out("iso", 1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
    step(0, 0, 0, 1, 0);
    expect_out("off", 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (5) step(0, 0, 0, 1, 0);
    expect_out("off_holds", 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1);
    step(0, 0, 1, 1, 0);
    expect_out("pwrup", 1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (7) step(0, 0, 0, 1, 0);
    expect_out("pwrup_7", 1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1);
    step(0, 0, 0, 1, 0);
    expect_out("pwrup_to_wakeup", 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (4) step(0, 0, 0, 0, 0);
    expect_out("deep_active", 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
    step(0, 0, 0, 0, 1);
    expect_out("ret_lost_clr", 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);

    // Wake seen during ISO is held pending through OFF.
    step(0, 1, 0, 1, 0);
    repeat (8) step(0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    expect_out("off_pending", 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1);
    step(0, 0, 0, 0, 0);
    expect_out("pending_pwrup", 1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (8) step(0, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    repeat (8) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    expect_out("off_again", 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1);
    do_reset("reset_mid_off");
`else
    repeat (20) step(0, 0, 0, 1, 0);
    expect_out("no_deep", 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    do_reset("reset_mid_sleep");
`endif

    // Randomised traffic in phases of decreasing activity density.
    for (int chunk = 0; chunk < 16; chunk++) begin
      case (chunk % 4)
        0:       pct = 40;
        1:       pct = 10;
        2:       pct = 3;
        default: pct = 0;
      endcase
      r_sen = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) do_reset("reset_rand");
      for (int i = 0; i < 250; i++) begin
        r_act = ($urandom_range(0, 99) < pct);
        step(r_act, $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 3, r_sen,
             $urandom_range(0, 99) < 5);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
